// File: rtl/uart_crc_receiver.sv
// CRC-8 UART frame receiver: data byte + CRC byte (8N1, LSB first), CRC-8 check on the data byte.
// Optional macro RX_TIMEOUT_EN enables the inter-character gap timeout.
module uart_crc_receiver #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter logic [7:0]  CRC_POLY     = 8'h07,
   parameter logic [7:0]  CRC_INIT     = 8'h00,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic [7:0] crc_out,
   output logic       data_valid,
   output logic       crc_error,
   output logic       frame_error,
   output logic       rx_busy
);

   localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP, CHECK, WAIT_HIGH} state_t;

   state_t           state, state_n;
   logic             rx_meta, rx_s;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [2:0]       bit_cnt, bit_cnt_n;
   logic [7:0]       shift, shift_n;
   logic [7:0]       data_byte, data_byte_n;
   logic             byte_idx, byte_idx_n;
   logic             accept, abort;
   logic [7:0]       crc_calc;

`ifdef RX_TIMEOUT_EN
   localparam int unsigned   TO_W    = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
   logic [TO_W-1:0] tcnt, tcnt_n;
`endif

   function automatic logic [7:0] crc8(input logic [7:0] d);
      logic [7:0] c;
      c = CRC_INIT ^ d;
      for (int unsigned i = 0; i < 8; i++)
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      return c;
   endfunction

   assign crc_calc = crc8(data_byte);
   assign rx_busy  = (state == START) || (state == DATA) || (state == STOP) || (state == GAP);

   // Synchroniser resets to the idle-high level so reset release cannot look like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         data_byte <= '0;
         byte_idx  <= 1'b0;
`ifdef RX_TIMEOUT_EN
         tcnt      <= '0;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         bit_cnt   <= bit_cnt_n;
         shift     <= shift_n;
         data_byte <= data_byte_n;
         byte_idx  <= byte_idx_n;
`ifdef RX_TIMEOUT_EN
         tcnt      <= tcnt_n;
`endif
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      bit_cnt_n   = bit_cnt;
      shift_n     = shift;
      data_byte_n = data_byte;
      byte_idx_n  = byte_idx;
      accept      = 1'b0;
      abort       = 1'b0;
`ifdef RX_TIMEOUT_EN
      tcnt_n      = tcnt;
`endif
      case (state)
         IDLE: begin
            if (!rx_s) begin
               byte_idx_n = 1'b0;
               cnt_n      = '0;
               state_n    = START;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_n     = '0;
               bit_cnt_n = '0;
               if (rx_s) state_n = byte_idx ? GAP : IDLE;
               else      state_n = DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_n     = '0;
               shift_n   = {rx_s, shift[7:1]};
               bit_cnt_n = bit_cnt + 1'b1;
               if (bit_cnt == 3'd7) state_n = STOP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_n = '0;
               if (!rx_s) begin
                  abort   = 1'b1;
                  state_n = WAIT_HIGH;
               end else if (!byte_idx) begin
                  data_byte_n = shift;
                  byte_idx_n  = 1'b1;
                  state_n     = GAP;
`ifdef RX_TIMEOUT_EN
                  tcnt_n      = '0;
`endif
               end else begin
                  // Results register on this edge so the strobe lands in the CHECK cycle.
                  accept  = 1'b1;
                  state_n = CHECK;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         GAP: begin
            if (!rx_s) begin
               cnt_n   = '0;
               state_n = START;
            end
`ifdef RX_TIMEOUT_EN
            else if (tcnt == TO_LAST) begin
               abort   = 1'b1;
               state_n = IDLE;
            end else begin
               tcnt_n = tcnt + 1'b1;
            end
`endif
         end
         CHECK:     state_n = IDLE;
         WAIT_HIGH: if (rx_s) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_out    <= '0;
         crc_out     <= '0;
         crc_error   <= 1'b0;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         data_valid  <= accept;
         frame_error <= abort;
         if (accept) begin
            data_out  <= data_byte;
            crc_out   <= shift;
            crc_error <= (crc_calc != shift);
         end
      end
   end

endmodule

// File: doc/uart_crc_receiver.md
# uart_crc_receiver

Serial receiver for the CRC-8 UART link. It sits directly downstream of the UART transmitter on the far end of the wire. It deserialises a two-character frame (data byte, then CRC byte, each 8N1, LSB first), recomputes CRC-8 over the data byte and compares the result with the received CRC. It presents the data byte, the received CRC and a one-cycle `data_valid` strobe with a `crc_error` flag to the consuming logic.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit (50 MHz / 115200 baud); minimum 4.
- `CRC_POLY`, 8'h07, CRC-8 generator polynomial (x^8 term implicit).
- `CRC_INIT`, 8'h00, CRC register initial value; no final XOR, no reflection.
- `TIMEOUT_BITS`, 20, inter-character gap limit in bit periods; used only with `RX_TIMEOUT_EN`.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-low reset.
- `rx_in` in 1: serial line; idle high; asynchronous to `clk`.
- `data_out` out 8: last received data byte; held until the next `data_valid`.
- `crc_out` out 8: last received CRC byte; held until the next `data_valid`.
- `data_valid` out 1: one-cycle strobe when a complete frame has been accepted.
- `crc_error` out 1: valid with `data_valid`; 1 when computed CRC ≠ `crc_out`; held with `data_out`.
- `frame_error` out 1: one-cycle strobe when a frame is aborted.
- `rx_busy` out 1: high while a frame is in progress.

## Operation
- `rx_in` passes through a 2-flop synchroniser; all logic below uses the synchronised value `rx_s`.
- FSM states: IDLE, START, DATA, STOP, GAP, CHECK, WAIT_HIGH. A 1-bit `byte_idx` selects data (0) or CRC (1) character.
- IDLE: when `rx_s` is 0, set `byte_idx` to 0, clear the counter, go to START, and raise `rx_busy`.
- START: after CLKS_PER_BIT/2 cycles (integer divide), sample `rx_s`.
  - If the sample is 1, it is a false start. For `byte_idx` 0, go back to IDLE with no strobe. For `byte_idx` 1, go back to GAP.
  - If the sample is 0, go to DATA.
- DATA: sample every CLKS_PER_BIT cycles. Shift the sample into bit[7] of the shift register (LSB-first assembly). After 8 samples, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
  - 0 → pulse `frame_error`, drop `rx_busy`, go to WAIT_HIGH.
  - 1 with `byte_idx` 0 → latch the byte as data, set `byte_idx` to 1, go to GAP.
  - 1 with `byte_idx` 1 → latch the byte as CRC, go to CHECK.
- GAP: on `rx_s` = 0, go to START.
- CHECK: takes one cycle. Compute the CRC as follows:
  - Load `CRC_INIT ^ data`.
  - Apply 8 MSB-first iterations of: if msb, (crc<<1)^CRC_POLY, else crc<<1.
  - Implement this combinationally.
  - Register `data_out`, `crc_out` and `crc_error`, pulse `data_valid`, drop `rx_busy`, go to IDLE.
- WAIT_HIGH: stay until `rx_s` = 1, then go to IDLE. This keeps a held-low (break) line from retriggering.
- Reset value of every output is 0. Asserting `reset` mid-frame discards the partial frame; there is no strobe after reset release.

## Timing
- Input latency: 2 cycles of synchroniser delay from `rx_in` to `rx_s`.
- Sampling points: the start-bit check is at CLKS_PER_BIT/2 after the falling edge is detected. Each data and stop sample follows the previous one by CLKS_PER_BIT cycles.
- `data_valid`, `crc_error`, `data_out` and `crc_out` update in the cycle immediately after the CRC stop-bit sample edge. `data_valid` is high for exactly 1 cycle.
- `frame_error` is high for exactly 1 cycle, in the cycle after the failing stop sample.
- `data_valid` and `frame_error` are never high in the same cycle.
- A new frame's start bit is accepted from the first cycle back in IDLE. Back-to-back frames with zero idle bits are supported.
- No handshake with the consumer. A strobe missed by the consumer is lost.

## Configuration
- `RX_TIMEOUT_EN` defined:
  - A counter runs in GAP.
  - If no start bit is seen within TIMEOUT_BITS×CLKS_PER_BIT cycles after the data stop sample, pulse `frame_error`, drop `rx_busy` and go to IDLE.
- `RX_TIMEOUT_EN` undefined: GAP waits indefinitely. There is no counter logic, and `TIMEOUT_BITS` is ignored.

## Test plan
- Send 0x55 then 0xAC (CLKS_PER_BIT=434) → `data_valid` pulse; `data_out`=0x55, `crc_out`=0xAC, `crc_error`=0.
- Send 0x55 then 0xA3 → `data_valid` pulse, `crc_error`=1. Send 0xFF then 0x00 → `crc_error`=1; 0xFF then 0xF3 → `crc_error`=0.
- Data stop bit driven 0 → single `frame_error` pulse, no `data_valid`. The line is held low for 30 bit periods then released, and 0x00/0x00 is sent (CRC 0x00 over 0x00 = 0x00) → `data_valid`, `crc_error`=0.
- 0.3-bit-period low glitch in idle → no `rx_busy` beyond the START check, and no strobes.
- Assert `reset` during DATA of the CRC byte, then release and send 0x12/0x7E → all outputs 0 during reset. Then exactly one `data_valid` with `data_out`=0x12 and `crc_error`=0.
- With `RX_TIMEOUT_EN`: send the data byte only and wait 21 bit periods → `frame_error` pulse at 20 bit periods after the stop sample, and `rx_busy` goes to 0.
